floor_tracker: RTL and testbench

Parametrised elevator floor tracker. It debounces the two floor-pass sensor lines and counts the cabin floor on their rising edges, saturating at a configurable floor range. It holds an optional target floor, drives a direction request toward it, and pulses on arrival. It sits between the shaft-sensor inputs and the motor/display control logic, replacing the fixed 4-bit up/down floor register.

---
 rtl/floor_tracker.sv | 166 ++++++++++++++++
 tb/tb_floor_tracker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/floor_tracker.sv
// Elevator floor tracker: debounced shaft sensors drive a saturating floor count,
// with an optional target floor, a direction request and arrival/fault pulses.
module floor_tracker #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned MIN_FLOOR  = 1,
    parameter int unsigned MAX_FLOOR  = 9,
    parameter int unsigned DEBOUNCE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            signal,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_floor,
    input  logic                  target_valid,
    input  logic [DATA_WIDTH-1:0] target,
    output logic [DATA_WIDTH-1:0] floor,
    output logic [1:0]            dir,
    output logic                  arrive,
    output logic                  fault
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    localparam logic [DATA_WIDTH-1:0] MIN_F    = DATA_WIDTH'(MIN_FLOOR);
    localparam logic [DATA_WIDTH-1:0] MAX_F    = DATA_WIDTH'(MAX_FLOOR);
    localparam logic [CW-1:0]         CNT_LAST = CW'(DEBOUNCE - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_UP   = 2'b01;
    localparam logic [1:0] ST_DOWN = 2'b10;

    logic [CW-1:0]         cnt_q [2];
    logic [CW-1:0]         cnt_d [2];
    logic [1:0]            filt_q, filt_d;
    logic [1:0]            filt_prev_q;
    logic [DATA_WIDTH-1:0] floor_q, floor_d;
    logic [DATA_WIDTH-1:0] tgt_q, tgt_d;
    logic                  tgt_v_q, tgt_v_d;
    logic [1:0]            dir_q, dir_d;
    logic                  arrive_q, arrive_d;
    logic                  fault_q, fault_d;

    logic up, dn;
    logic load_ok, target_ok;

    // Filtered level follows the raw level only after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (signal[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = signal[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign up        = filt_q[1] & ~filt_prev_q[1];
    assign dn        = filt_q[0] & ~filt_prev_q[0];
    assign load_ok   = (load_floor >= MIN_F) && (load_floor <= MAX_F);
    assign target_ok = (target >= MIN_F) && (target <= MAX_F);

    always_comb begin
        floor_d  = floor_q;
        fault_d  = 1'b0;
        tgt_d    = tgt_q;
        tgt_v_d  = tgt_v_q;
        dir_d    = dir_q;
        arrive_d = 1'b0;

        // A load wins outright; sensor edges in the same cycle are dropped silently.
        if (load) begin
            if (load_ok) begin
                floor_d = load_floor;
            end else begin
                fault_d = 1'b1;
            end
        end else if (up && dn) begin
            fault_d = 1'b1;
        end else if (up) begin
            if (floor_q == MAX_F) begin
                fault_d = 1'b1;
            end else begin
                floor_d = floor_q + 1'b1;
            end
        end else if (dn) begin
            if (floor_q == MIN_F) begin
                fault_d = 1'b1;
            end else begin
                floor_d = floor_q - 1'b1;
            end
        end

        case (dir_q)
            ST_IDLE: begin
                if (tgt_v_q) begin
                    if (tgt_q > floor_q) begin
                        dir_d = ST_UP;
                    end else if (tgt_q < floor_q) begin
                        dir_d = ST_DOWN;
                    end else begin
                        arrive_d = 1'b1;
                        tgt_v_d  = 1'b0;
                    end
                end
            end
            ST_UP, ST_DOWN: begin
                if (!tgt_v_q || (tgt_q == floor_q)) begin
                    dir_d    = ST_IDLE;
                    arrive_d = tgt_v_q;
                    tgt_v_d  = 1'b0;
                end else if (tgt_q > floor_q) begin
                    dir_d = ST_UP;
                end else begin
                    dir_d = ST_DOWN;
                end
            end
            default: dir_d = ST_IDLE;
        endcase

        // A fresh target overrides any clear from an arrival in the same cycle.
        if (target_valid) begin
            if (target_ok) begin
                tgt_d   = target;
                tgt_v_d = 1'b1;
            end else begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            filt_q      <= 2'b00;
            filt_prev_q <= 2'b00;
            floor_q     <= MIN_F;
            tgt_q       <= MIN_F;
            tgt_v_q     <= 1'b0;
            dir_q       <= ST_IDLE;
            arrive_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            floor_q     <= floor_d;
            tgt_q       <= tgt_d;
            tgt_v_q     <= tgt_v_d;
            dir_q       <= dir_d;
            arrive_q    <= arrive_d;
            fault_q     <= fault_d;
        end
    end

    assign floor  = floor_q;
    assign dir    = dir_q;
    assign arrive = arrive_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_floor_tracker.sv
// Scoreboard bench for floor_tracker: stimulus queues expected output events with
// their cycle numbers; a negedge monitor pops and compares every observed event.
module tb_floor_tracker;

    localparam int K_FLOOR  = 0;
    localparam int K_DIR    = 1;
    localparam int K_ARRIVE = 2;
    localparam int K_FAULT  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] signal = 2'b00;
    logic       load = 1'b0;
    logic [3:0] load_floor = 4'd0;
    logic       target_valid = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] floor;
    logic [1:0] dir;
    logic       arrive;
    logic       fault;

    floor_tracker #(
        .DATA_WIDTH(4),
        .MIN_FLOOR (1),
        .MAX_FLOOR (9),
        .DEBOUNCE  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .signal      (signal),
        .load        (load),
        .load_floor  (load_floor),
        .target_valid(target_valid),
        .target      (target),
        .floor       (floor),
        .dir         (dir),
        .arrive      (arrive),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;
    logic [3:0] prev_floor = 4'd1;
    logic [1:0] prev_dir = 2'b00;

    function automatic string kname(input int k);
        case (k)
            K_FLOOR:  return "floor";
            K_DIR:    return "dir";
            K_ARRIVE: return "arrive";
            default:  return "fault";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int val, input int dly);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = cyc + dly;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_%s: got %s=%0d at cycle %0d, required no event",
                     kname(kind), kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.val == val && e.cyc == cyc) begin
                n_pass++;
            end else begin
                $display("FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                         kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (floor !== prev_floor) begin
                observe(K_FLOOR, int'(floor));
                prev_floor = floor;
            end
            if (dir !== prev_dir) begin
                observe(K_DIR, int'(dir));
                prev_dir = dir;
            end
            if (arrive !== 1'b0) observe(K_ARRIVE, 1);
            if (fault !== 1'b0) observe(K_FAULT, 1);
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Hold a sensor pattern long enough to debounce, then release and let it settle.
    task automatic pass(input logic [1:0] bits);
        signal = bits;
        tick(4);
        signal = 2'b00;
        tick(6);
    endtask

    task automatic do_load(input logic [3:0] v);
        load       = 1'b1;
        load_floor = v;
        tick(1);
        load = 1'b0;
        tick(2);
    endtask

    task automatic do_target(input logic [3:0] v);
        target_valid = 1'b1;
        target       = v;
        tick(1);
        target_valid = 1'b0;
        tick(2);
    endtask

    initial begin
        tick(3);
        check("reset_floor", int'(floor), 1);
        check("reset_dir", int'(dir), 0);
        check("reset_arrive", int'(arrive), 0);
        check("reset_fault", int'(fault), 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Up pass: floor 1 -> 2 four edges after first sample.
        expect_ev(K_FLOOR, 2, 5);
        pass(2'b10);

        // Three-cycle glitch: no events.
        signal = 2'b10;
        tick(3);
        signal = 2'b00;
        tick(5);

        // Saturate at top, then out-of-range load.
        expect_ev(K_FLOOR, 9, 1);
        do_load(4'd9);
        expect_ev(K_FAULT, 1, 5);
        pass(2'b10);
        expect_ev(K_FAULT, 1, 1);
        do_load(4'd12);

        // Saturate at bottom.
        expect_ev(K_FLOOR, 1, 1);
        do_load(4'd1);
        expect_ev(K_FAULT, 1, 5);
        pass(2'b01);

        // Travel from 3 to target 5.
        expect_ev(K_FLOOR, 3, 1);
        do_load(4'd3);
        expect_ev(K_DIR, 1, 2);
        do_target(4'd5);
        expect_ev(K_FLOOR, 4, 5);
        pass(2'b10);
        expect_ev(K_FLOOR, 5, 5);
        expect_ev(K_DIR, 0, 6);
        expect_ev(K_ARRIVE, 1, 6);
        pass(2'b10);

        // Simultaneous up/down, rejected target, same-floor target.
        expect_ev(K_FAULT, 1, 5);
        pass(2'b11);
        expect_ev(K_FAULT, 1, 1);
        do_target(4'd0);
        expect_ev(K_ARRIVE, 1, 2);
        do_target(4'd5);

        // Reset while heading down with a debounce in progress.
        expect_ev(K_DIR, 2, 2);
        do_target(4'd2);
        signal = 2'b10;
        tick(2);
        expect_ev(K_FLOOR, 1, 1);
        expect_ev(K_DIR, 0, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_ev(K_FLOOR, 2, 5);
        pass(2'b10);

        tick(4);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
